// File: rtl/aes_enc_seq.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Optional abort input is enabled by defining AES_ENC_SEQ_ABORT_EN.
module aes_enc_seq #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] Data_in,
    input  logic [127:0] Key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Data_out,
`ifdef AES_ENC_SEQ_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic [3:0]   round_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_t         fsm_reg;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [7:0]   rcon;
    logic [31:0]  w3_sub, w4, w5, w6, w7;
    logic [127:0] rk_next;
    logic [127:0] sub_state, shift_state, mix_state, round_out;
    logic         abort_hit;

`ifdef AES_ENC_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        rcon = 8'h00;
        case (round_cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord then SubWord on the last word of the previous round key.
    assign w3_sub = {sbox(rk_reg[23:16]) ^ rcon, sbox(rk_reg[15:8]),
                     sbox(rk_reg[7:0]), sbox(rk_reg[31:24])};
    assign w4 = rk_reg[127:96] ^ w3_sub;
    assign w5 = rk_reg[95:64] ^ w4;
    assign w6 = rk_reg[63:32] ^ w5;
    assign w7 = rk_reg[31:0] ^ w6;
    assign rk_next = {w4, w5, w6, w7};

    // Byte gi sits at row gi%4, column gi/4; ShiftRows pulls row r from column c+r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
        localparam int ROW = gi % 4;
        localparam int SRC = 4 * (((gi / 4) + ROW) % 4) + ROW;
        assign sub_state[127-8*gi -: 8]   = sbox(state_reg[127-8*gi -: 8]);
        assign shift_state[127-8*gi -: 8] = sub_state[127-8*SRC -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_cols
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shift_state[127-32*gi -: 8];
        assign a1 = shift_state[119-32*gi -: 8];
        assign a2 = shift_state[111-32*gi -: 8];
        assign a3 = shift_state[103-32*gi -: 8];
        assign mix_state[127-32*gi -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

    assign round_out = ((round_cnt == LAST_ROUND) ? shift_state : mix_state) ^ rk_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            rk_reg    <= '0;
            round_cnt <= '0;
            Data_out  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= Data_in ^ Key;
                        rk_reg    <= Key;
                        round_cnt <= 4'd1;
                        fsm_reg   <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        fsm_reg   <= IDLE;
                        round_cnt <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_reg <= round_out;
                        rk_reg    <= rk_next;
                        round_cnt <= round_cnt + 4'd1;
                        if (round_cnt == LAST_ROUND) begin
                            fsm_reg   <= DONE;
                            Data_out  <= round_out;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Abort and a consumer handshake both end the job; Data_out keeps its value.
                    if (abort_hit || out_ready) begin
                        fsm_reg   <= IDLE;
                        round_cnt <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm_reg   <= IDLE;
                    round_cnt <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
